// File: rtl/temp_to_bcd_n.sv
// Signed fixed-point temperature -> sign, INT_DIGITS BCD digits and a tenths digit.
// The integer part is converted by iterative double-dabble. Define BCD_BLANK_ZERO_EN to blank leading zero digits as 4'hF.
module temp_to_bcd_n #(
  parameter int IN_W       = 13,
  parameter int FRAC_W     = 4,
  parameter int INT_DIGITS = 3,
  parameter int OFS_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         temp,
  input  logic [OFS_W-1:0]        ofs,
  input  logic                    sub_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign,
  output logic [4*INT_DIGITS-1:0] digits,
  output logic [3:0]              frac_digit,
  output logic                    overflow
);
  localparam int INT_W = IN_W - FRAC_W;
  localparam int BCD_W = 4 * INT_DIGITS;
  localparam int CNT_W = $clog2(INT_W + 1);
  localparam logic [31:0] MAX_IP = (INT_DIGITS == 1) ? 32'd9 :
                                   (INT_DIGITS == 2) ? 32'd99 :
                                   (INT_DIGITS == 3) ? 32'd999 : 32'd9999;

  typedef enum logic [1:0] {IDLE, PREP, CONV, DONE} state_t;
  state_t state, state_n;

  logic [IN_W-1:0]  temp_r;
  logic [OFS_W-1:0] ofs_r;
  logic             sub_r;
  logic [INT_W-1:0] bin_r;
  logic [BCD_W-1:0] bcd_r, bcd_adj, disp;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       frac_r;
  logic             neg_r, ovf_r;

  logic [IN_W:0]       ofs_ext, off, off_abs;
  logic [IN_W-1:0]     mag;
  logic [FRAC_W+3:0]   frac_prod;
  logic [3:0]          frac_c;
  logic [INT_W-1:0]    ip_c;
  logic                neg_c, ovf_c;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = PREP;
      PREP:    state_n = CONV;
      CONV:    if (cnt == CNT_W'(INT_W - 1)) state_n = DONE;
      DONE:    if (out_valid && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Offset subtraction is one bit wider than temp so it never wraps.
  always_comb begin
    ofs_ext   = {{(IN_W + 1 - OFS_W - FRAC_W){1'b0}}, ofs_r, {FRAC_W{1'b0}}};
    off       = {temp_r[IN_W-1], temp_r} - (sub_r ? ofs_ext : '0);
    off_abs   = off[IN_W] ? (~off + {{IN_W{1'b0}}, 1'b1}) : off;
    mag       = IN_W'(off_abs);
    frac_prod = {4'b0, mag[FRAC_W-1:0]} * (FRAC_W + 4)'(10);
    frac_c    = 4'(frac_prod >> FRAC_W);
    ip_c      = mag[IN_W-1:FRAC_W];
    ovf_c     = 32'(ip_c) > MAX_IP;
    neg_c     = off[IN_W] && !(ip_c == '0 && frac_c == 4'd0);
  end

  always_comb begin
    bcd_adj = bcd_r;
    for (int d = 0; d < INT_DIGITS; d++)
      if (bcd_r[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
  end

  always_comb begin
    disp = bcd_r;
`ifdef BCD_BLANK_ZERO_EN
    begin
      logic lead;
      lead = 1'b1;
      // The least significant digit stays visible so a zero still reads "0".
      for (int d = INT_DIGITS - 1; d >= 1; d--) begin
        if (lead && bcd_r[4*d +: 4] == 4'd0) disp[4*d +: 4] = 4'hF;
        else                                 lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        temp_r <= temp;
        ofs_r  <= ofs;
        sub_r  <= sub_en;
      end
      PREP: begin
        bin_r  <= ip_c;
        bcd_r  <= '0;
        cnt    <= '0;
        frac_r <= frac_c;
        neg_r  <= neg_c;
        ovf_r  <= ovf_c;
      end
      CONV: begin
        bcd_r <= BCD_W'({bcd_adj, bin_r[INT_W-1]});
        bin_r <= bin_r << 1;
        cnt   <= cnt + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      sign       <= 1'b0;
      digits     <= '0;
      frac_digit <= 4'd0;
      overflow   <= 1'b0;
    end else if (state == DONE && !out_valid) begin
      out_valid  <= 1'b1;
      sign       <= neg_r;
      overflow   <= ovf_r;
      digits     <= ovf_r ? {INT_DIGITS{4'h9}} : disp;
      frac_digit <= ovf_r ? 4'd9 : frac_r;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
